// File: rtl/dr_scan_bank_pkg.sv
// Shared types and constants for the multi-channel JTAG user data-register bank.
// Holds the default geometry, the bypass capture value and the strobe priority decode.
package dr_scan_bank_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned NCHAN_DEF = 4;
  localparam int unsigned SEL_W_DEF = 3;

  // Value loaded into the 1-bit bypass stage on capture
  localparam logic BYPASS_CAP = 1'b0;

  typedef struct packed {
    logic capture;
    logic shift;
    logic update;
  } dr_strobe_t;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'd0,
    OP_CAPTURE = 2'd1,
    OP_SHIFT   = 2'd2,
    OP_UPDATE  = 2'd3
  } dr_op_e;

  // Coinciding strobes resolve capture > shift > update
  function automatic dr_op_e decode_op(input dr_strobe_t s);
    dr_op_e op;
    op = OP_IDLE;
    if (s.capture)     op = OP_CAPTURE;
    else if (s.shift)  op = OP_SHIFT;
    else if (s.update) op = OP_UPDATE;
    return op;
  endfunction

endpackage

// File: rtl/dr_scan_bank_if.sv
// TAP-side serial/strobe bundle between the TAP controller and the DR bank.
interface dr_scan_bank_if #(
  parameter int unsigned SEL_W = 3
) ();

  logic [SEL_W-1:0] sel;
  logic             captureDR;
  logic             shiftDR;
  logic             updateDR;
  logic             tdi;
  logic             tdo;

  modport master (
    output sel,
    output captureDR,
    output shiftDR,
    output updateDR,
    output tdi,
    input  tdo
  );

  modport slave (
    input  sel,
    input  captureDR,
    input  shiftDR,
    input  updateDR,
    input  tdi,
    output tdo
  );

endinterface

// File: rtl/dr_scan_chan.sv
// One WIDTH-bit scan channel: parallel capture, LSB-first shift, registered update with commit pulse.
module dr_scan_chan #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             tck,
  input  logic             reset,
  input  logic             cap_en,
  input  logic             shift_en,
  input  logic             upd_en,
  input  logic             tdi,
  input  logic [WIDTH-1:0] cap_data,
  output logic             sr_lsb,
  output logic [WIDTH-1:0] upd_data,
  output logic             upd_valid
);

  logic [WIDTH-1:0] sr;

  // Scan register; enables are already mutually exclusive from the top-level decode
  always_ff @(posedge tck or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else if (cap_en) begin
      sr <= cap_data;
    end else if (shift_en) begin
      sr <= {tdi, sr[WIDTH-1:1]};
    end
  end

  // upd_en is asserted only for a length-checked update, so valid is a clean one-cycle pulse
  always_ff @(posedge tck or negedge reset) begin
    if (!reset) begin
      upd_data  <= '0;
      upd_valid <= 1'b0;
    end else begin
      upd_valid <= upd_en;
      if (upd_en) begin
        upd_data <= sr;
      end
    end
  end

  assign sr_lsb = sr[0];

endmodule

// File: rtl/dr_scan_bank.sv
// Multi-channel JTAG user data-register bank with bypass fallback and shift-length checked update.
// Holds the scan select, bypass stage, shift counter, length error flag and tdo mux.
module dr_scan_bank
  import dr_scan_bank_pkg::*;
#(
  parameter  int unsigned WIDTH = WIDTH_DEF,
  parameter  int unsigned NCHAN = NCHAN_DEF,
  parameter  int unsigned SEL_W = SEL_W_DEF,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1) + 1
) (
  input  logic                   tck,
  input  logic                   reset,
  dr_scan_bank_if.slave          tap,
  input  logic [NCHAN*WIDTH-1:0] cap_data,
  output logic [NCHAN*WIDTH-1:0] upd_data,
  output logic [NCHAN-1:0]       upd_valid,
  output logic [CNT_W-1:0]       shift_count,
  output logic                   len_err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [SEL_W-1:0] SEL_LIM  = SEL_W'(NCHAN);

  logic [SEL_W-1:0] sel_q;
  logic             byp_q;

  dr_strobe_t       strobe_c;
  dr_op_e           op_c;
  logic             sel_hit_c;
  logic             selq_hit_c;
  logic             commit_c;
  logic             tdo_c;

  logic [NCHAN-1:0] cap_en_c;
  logic [NCHAN-1:0] shift_en_c;
  logic [NCHAN-1:0] upd_en_c;
  logic [NCHAN-1:0] sr_lsb;

  assign strobe_c   = '{capture: tap.captureDR, shift: tap.shiftDR, update: tap.updateDR};
  assign op_c       = decode_op(strobe_c);
  assign sel_hit_c  = (tap.sel < SEL_LIM);
  assign selq_hit_c = (sel_q < SEL_LIM);
  assign commit_c   = (op_c == OP_UPDATE) && selq_hit_c && (shift_count == CNT_FULL);

  // Capture is steered by the live select; shift and update follow the captured select
  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    assign cap_en_c[c]   = (op_c == OP_CAPTURE) && (tap.sel == SEL_W'(c));
    assign shift_en_c[c] = (op_c == OP_SHIFT)   && (sel_q   == SEL_W'(c));
    assign upd_en_c[c]   = commit_c             && (sel_q   == SEL_W'(c));

    dr_scan_chan #(
      .WIDTH (WIDTH)
    ) u_chan (
      .tck       (tck),
      .reset     (reset),
      .cap_en    (cap_en_c[c]),
      .shift_en  (shift_en_c[c]),
      .upd_en    (upd_en_c[c]),
      .tdi       (tap.tdi),
      .cap_data  (cap_data[c*WIDTH +: WIDTH]),
      .sr_lsb    (sr_lsb[c]),
      .upd_data  (upd_data[c*WIDTH +: WIDTH]),
      .upd_valid (upd_valid[c])
    );
  end

  // Scan bookkeeping: select, bypass stage, saturating shift count, sticky length error
  always_ff @(posedge tck or negedge reset) begin
    if (!reset) begin
      sel_q       <= '0;
      byp_q       <= 1'b0;
      shift_count <= '0;
      len_err     <= 1'b0;
    end else begin
      unique case (op_c)
        OP_CAPTURE: begin
          sel_q       <= tap.sel;
          shift_count <= '0;
          len_err     <= 1'b0;
          if (!sel_hit_c) begin
            byp_q <= BYPASS_CAP;
          end
        end
        OP_SHIFT: begin
          if (!selq_hit_c) begin
            byp_q <= tap.tdi;
          end
          if (shift_count != CNT_MAX) begin
            shift_count <= shift_count + CNT_W'(1);
          end
        end
        OP_UPDATE: begin
          if (selq_hit_c && (shift_count != CNT_FULL)) begin
            len_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Serial out: selected channel LSB, or the bypass stage for an out-of-range select
  always_comb begin
    tdo_c = byp_q;
    for (int c = 0; c < NCHAN; c++) begin
      if (sel_q == SEL_W'(c)) begin
        tdo_c = sr_lsb[c];
      end
    end
  end

  assign tap.tdo = tdo_c;

endmodule
